sub_div_recover: RTL and testbench

SUB_DIV_RECOVER -- requirements
Module: sub_div_recover

---
 rtl/sub_div_recover.sv | 168 ++++++++++++++++
 tb/tb_sub_div_recover.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sub_div_recover.sv
// Recovers A from Y = A*B + C: subtract C, then restoring division by B, one quotient bit per cycle.
// Reports divide-by-zero, underflow (Y < C) and quotient overflow alongside the result.
package params;
    localparam int DATA_WIDTH     = 8;
    localparam int DATA_OUT_WIDTH = 16;
endpackage

module sub_div_recover #(
    parameter int DATA_WIDTH     = params::DATA_WIDTH,
    parameter int DATA_OUT_WIDTH = params::DATA_OUT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_OUT_WIDTH-1:0] DATA_IN,
    input  logic [DATA_WIDTH-1:0]     B,
    input  logic [DATA_WIDTH-1:0]     C,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     A_OUT,
    output logic [DATA_WIDTH-1:0]     REM_OUT,
    output logic                      err_div0,
    output logic                      err_under,
    output logic                      err_ovf
);

    localparam int CW = $clog2(DATA_OUT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

    state_t                      state_q, state_d;
    logic [DATA_OUT_WIDTH-1:0]   y_q, y_d;
    logic [DATA_WIDTH-1:0]       b_q, b_d;
    logic [DATA_WIDTH-1:0]       c_q, c_d;
    logic [DATA_OUT_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]       rem_q, rem_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       a_q, a_d;
    logic [DATA_WIDTH-1:0]       r_q, r_d;
    logic                        div0_q, div0_d;
    logic                        under_q, under_d;
    logic                        ovf_q, ovf_d;

    logic [DATA_OUT_WIDTH-1:0]   c_ext;
    logic [DATA_OUT_WIDTH-1:0]   sub_res;
    logic                        sub_under;
    logic [DATA_WIDTH:0]         trial;
    logic                        trial_ge;
    logic [DATA_WIDTH-1:0]       rem_step;
    logic [DATA_OUT_WIDTH-1:0]   quo_step;

    // quo_q doubles as the dividend shift register: dividend bits leave at the top,
    // quotient bits enter at the bottom, so after the last step it holds Q.
    always_comb begin
        c_ext     = {{(DATA_OUT_WIDTH - DATA_WIDTH){1'b0}}, c_q};
        sub_res   = y_q - c_ext;
        sub_under = y_q < c_ext;
        trial     = {rem_q, quo_q[DATA_OUT_WIDTH-1]};
        trial_ge  = trial >= {1'b0, b_q};
        rem_step  = trial_ge ? (trial[DATA_WIDTH-1:0] - b_q) : trial[DATA_WIDTH-1:0];
        quo_step  = {quo_q[DATA_OUT_WIDTH-2:0], trial_ge};
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        b_d     = b_q;
        c_d     = c_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        r_d     = r_q;
        div0_d  = div0_q;
        under_d = under_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d     = DATA_IN;
                    b_d     = B;
                    c_d     = C;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (b_q == '0) begin
                    div0_d  = 1'b1;
                    a_d     = '1;
                    r_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else if (sub_under) begin
                    under_d = 1'b1;
                    a_d     = '0;
                    r_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    quo_d   = sub_res;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_OUT_WIDTH - 1)) begin
                    a_d     = quo_step[DATA_WIDTH-1:0];
                    r_d     = rem_step;
                    ovf_d   = |quo_step[DATA_OUT_WIDTH-1:DATA_WIDTH];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    div0_d  = 1'b0;
                    under_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            under_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            c_q     <= c_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
            under_q <= under_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign A_OUT     = a_q;
    assign REM_OUT   = r_q;
    assign err_div0  = div0_q;
    assign err_under = under_q;
    assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_sub_div_recover.sv
// Randomised and directed check of sub_div_recover against an arithmetic model of (Y-C)/B.
// Covers latency, backpressure hold, error cases and mid-operation reset.
module tb_sub_div_recover;
    localparam int DW  = 8;
    localparam int DOW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DOW-1:0] DATA_IN;
    logic [DW-1:0]  B;
    logic [DW-1:0]  C;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  A_OUT;
    logic [DW-1:0]  REM_OUT;
    logic           err_div0;
    logic           err_under;
    logic           err_ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sub_div_recover #(.DATA_WIDTH(DW), .DATA_OUT_WIDTH(DOW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .DATA_IN(DATA_IN), .B(B), .C(C),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_OUT(A_OUT), .REM_OUT(REM_OUT),
        .err_div0(err_div0), .err_under(err_under), .err_ovf(err_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the arithmetic definition.
    task automatic model(input int y, input int b, input int c,
                         output int a, output int r, output int d0, output int un, output int ov);
        int q;
        d0 = 0; un = 0; ov = 0;
        if (b == 0) begin
            a = 255; r = 0; d0 = 1;
        end else if (y < c) begin
            a = 0; r = 0; un = 1;
        end else begin
            q  = (y - c) / b;
            r  = (y - c) % b;
            a  = q % 256;
            ov = (q > 255) ? 1 : 0;
        end
    endtask

    task automatic run_txn(input int y, input int b, input int c, input int bp);
        int ea, er, ed, eu, eo, lat, exp_lat;
        logic [31:0] exp_word;
        model(y, b, c, ea, er, ed, eu, eo);
        exp_lat = (ed == 1 || eu == 1) ? 2 : DOW + 2;
        @(negedge clk);
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        DATA_IN  = DOW'(y);
        B        = DW'(b);
        C        = DW'(c);
        @(negedge clk);
        in_valid = 1'($urandom);
        DATA_IN  = DOW'($urandom);
        B        = DW'($urandom);
        C        = DW'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk("busy", {28'b0, in_ready, err_div0, err_under, err_ovf}, 32'd0);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        exp_word = {8'b0, DW'(ea), DW'(er), 5'b0, 1'(ed), 1'(eu), 1'(eo)};
        chk("result", {8'b0, A_OUT, REM_OUT, 5'b0, err_div0, err_under, err_ovf}, exp_word);
        $display("txn y=%0d b=%0d c=%0d -> a=%0d rem=%0d div0=%0b under=%0b ovf=%0b lat=%0d",
                 y, b, c, A_OUT, REM_OUT, err_div0, err_under, err_ovf, lat);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("hold", {6'b0, out_valid, in_ready, A_OUT, REM_OUT, 5'b0, err_div0, err_under, err_ovf},
                {6'b0, 1'b1, 1'b0, exp_word[23:0]});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs", {27'b0, out_valid, in_ready, err_div0, err_under, err_ovf}, 32'b01000);
    endtask

    initial begin
        int a, b, c, y, seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        DATA_IN   = '0;
        B         = '0;
        C         = '0;
        #1;
        chk("reset_state", {12'b0, in_ready, out_valid, A_OUT, REM_OUT, err_div0, err_under, err_ovf},
            {12'b0, 1'b1, 1'b0, 19'b0});
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        run_txn(305, 12, 5, 1);
        run_txn(16'hFFFF, 1, 0, 2);
        run_txn(1000, 7, 3, 0);
        run_txn(3, 4, 5, 1);
        run_txn(3, 0, 9, 1);
        run_txn(0, 0, 200, 0);
        run_txn(5, 5, 5, 0);
        run_txn(305, 12, 5, 10);

        // Abort in the fifth DIV cycle.
        @(negedge clk);
        in_valid = 1'b1; DATA_IN = 16'd305; B = 8'd12; C = 8'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {12'b0, in_ready, out_valid, A_OUT, REM_OUT, err_div0, err_under, err_ovf},
            {12'b0, 1'b1, 1'b0, 19'b0});
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ignore_valid", {30'b0, in_ready, out_valid}, 32'b10);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("no_valid_after_abort", 32'(seen), 32'd0);
        run_txn(305, 12, 5, 2);

        for (int t = 0; t < 1000; t++) begin
            if ($urandom_range(0, 9) != 0) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(1, 255);
                c = $urandom_range(0, 255);
                y = a * b + c;
            end else begin
                y = $urandom_range(0, 65535);
                b = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255);
                c = $urandom_range(0, 255);
            end
            run_txn(y, b, c, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
